// File: rtl/ws2812b_frame_scheduler.sv
// ws2812b_frame_scheduler: per-frame snapshot, peak-hold, serializer start handshake and pixel colour lookup
module ws2812b_frame_scheduler #(
  parameter int LED_W = 8,
  parameter int FRAME_PERIOD = 1666667,
  parameter int PEAK_HOLD_FRAMES = 30,
  parameter int PEAK_DECAY_FRAMES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             is_enable,
  input  logic [LED_W-1:0] level,
  input  logic [LED_W-1:0] max_count,
  input  logic [LED_W-1:0] thr_mid,
  input  logic [LED_W-1:0] thr_high,
  input  logic [23:0]      color_low,
  input  logic [23:0]      color_mid,
  input  logic [23:0]      color_high,
  input  logic [23:0]      color_peak,
  output logic             start_req,
  input  logic             start_ack,
  input  logic             frame_done,
  input  logic             pix_req,
  input  logic [LED_W-1:0] pix_idx,
  output logic             pix_valid,
  output logic [23:0]      pix_color,
  output logic [LED_W-1:0] peak_pos,
  output logic             busy,
  output logic [7:0]       overrun_cnt
);
  localparam int CW = $clog2(FRAME_PERIOD);
  localparam int HW = $clog2(PEAK_HOLD_FRAMES + 2);
  localparam int DW = $clog2(PEAK_DECAY_FRAMES + 1);
  localparam logic [2:0] IDLE = 3'd0, WAIT_TICK = 3'd1, LATCH = 3'd2, REQ = 3'd3, SEND = 3'd4;
  logic [2:0] state, nxt;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold;
  logic [DW-1:0] decay;
  logic [LED_W-1:0] lit, mx, tm, th, lit_n;
  logic [23:0] cl, cm, ch, cp, pc;
  logic tick;
  assign tick = is_enable && cnt == CW'(FRAME_PERIOD - 1);
  assign lit_n = level < max_count ? level : max_count;
  assign start_req = state == REQ;
  assign busy = state == REQ || state == SEND;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = is_enable ? WAIT_TICK : IDLE;
      WAIT_TICK: nxt = !is_enable ? IDLE : tick ? LATCH : WAIT_TICK;
      LATCH:     nxt = REQ;
      REQ:       nxt = start_ack ? SEND : !is_enable ? IDLE : REQ;
      SEND:      nxt = !frame_done ? SEND : is_enable ? WAIT_TICK : IDLE;
      default:   nxt = IDLE;
    endcase
  end
  // the peak marker is drawn even when it sits above the lit bar
  always_comb begin
    pc = 24'd0;
    if (pix_idx >= mx) pc = 24'd0;
    else if (peak_pos != '0 && pix_idx == peak_pos - 1'b1) pc = cp;
    else if (pix_idx < lit) pc = pix_idx < tm ? cl : pix_idx < th ? cm : ch;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      hold <= '0;
      decay <= '0;
      lit <= '0;
      mx <= '0;
      tm <= '0;
      th <= '0;
      cl <= '0;
      cm <= '0;
      ch <= '0;
      cp <= '0;
      peak_pos <= '0;
      overrun_cnt <= '0;
      pix_valid <= 1'b0;
      pix_color <= '0;
    end else begin
      state <= nxt;
      cnt <= (!is_enable || tick) ? '0 : cnt + 1'b1;
      if (tick && state != WAIT_TICK && overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 1'b1;
      if (state == LATCH) begin
        lit <= lit_n;
        mx <= max_count;
        tm <= thr_mid;
        th <= thr_high;
        cl <= color_low;
        cm <= color_mid;
        ch <= color_high;
        cp <= color_peak;
        if (lit_n >= peak_pos) begin
          peak_pos <= lit_n;
          hold <= HW'(PEAK_HOLD_FRAMES);
          decay <= '0;
        end else if (hold != '0) hold <= hold - 1'b1;
        else if (decay == DW'(PEAK_DECAY_FRAMES - 1)) begin
          decay <= '0;
          peak_pos <= peak_pos - 1'b1;
        end else decay <= decay + 1'b1;
      end
      pix_valid <= pix_req;
      pix_color <= pix_req ? pc : 24'd0;
    end
  end
endmodule

// File: tb/tb_ws2812b_frame_scheduler.sv
// tb_ws2812b_frame_scheduler: table vectors plus scoreboarded pixel lookups and handshake sequences
module tb_ws2812b_frame_scheduler;
  localparam logic [23:0] CL = 24'h110000, CM = 24'h002200, CH = 24'h000033, CP = 24'habcdef;
  logic clk = 0, reset = 1, is_enable = 0, start_ack = 0, frame_done = 0, pix_req = 0;
  logic [7:0] level = 0, max_count = 0, thr_mid = 0, thr_high = 0, pix_idx = 0;
  logic [23:0] color_low = CL, color_mid = CM, color_high = CH, color_peak = CP;
  logic start_req, pix_valid, busy;
  logic [23:0] pix_color;
  logic [7:0] peak_pos, overrun_cnt;
  int total = 0, bad = 0;
  logic [23:0] exp_q[$];
  typedef struct { logic [7:0] idx; logic [23:0] exp; } vec_t;
  vec_t tv[16];
  int peak_seq[22] = '{12, 12, 12, 12, 11, 11, 10, 10, 9, 9, 8, 8, 7, 7, 6, 6, 5, 5, 4, 4, 4, 4};

  always #5 clk = ~clk;

  ws2812b_frame_scheduler #(.LED_W(8), .FRAME_PERIOD(100), .PEAK_HOLD_FRAMES(2), .PEAK_DECAY_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .is_enable(is_enable), .level(level), .max_count(max_count),
    .thr_mid(thr_mid), .thr_high(thr_high), .color_low(color_low), .color_mid(color_mid),
    .color_high(color_high), .color_peak(color_peak), .start_req(start_req), .start_ack(start_ack),
    .frame_done(frame_done), .pix_req(pix_req), .pix_idx(pix_idx), .pix_valid(pix_valid),
    .pix_color(pix_color), .peak_pos(peak_pos), .busy(busy), .overrun_cnt(overrun_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) chk("pix", {7'd0, pix_valid, pix_color}, {7'd0, 1'b1, exp_q.pop_front()});
    else if (pix_valid) chk("pix_extra", {31'd0, pix_valid}, 32'd0);
  end

  task automatic pix(input logic [7:0] i, input logic [23:0] e);
    pix_req = 1;
    pix_idx = i;
    exp_q.push_back(e);
    @(negedge clk);
    pix_req = 0;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!start_req && n < 400);
    chk(nm, {31'd0, start_req}, 32'd1);
  endtask

  task automatic done_pulse();
    frame_done = 1;
    @(negedge clk);
    frame_done = 0;
  endtask

  task automatic frame(input string nm, input int pk);
    wait_req(nm);
    chk(nm, {24'd0, peak_pos}, pk);
    @(negedge clk);
    done_pulse();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tv[i].idx = 8'(i);
      tv[i].exp = i < 6 ? CL : i < 9 ? CM : i == 9 ? CP : 24'd0;
    end
    repeat (3) @(negedge clk);
    chk("rst_start_req", {31'd0, start_req}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_peak", {24'd0, peak_pos}, 0);
    chk("rst_overrun", {24'd0, overrun_cnt}, 0);
    chk("rst_pix", {7'd0, pix_valid, pix_color}, 0);
    level = 10; max_count = 16; thr_mid = 6; thr_high = 12;
    reset = 0; is_enable = 1;
    repeat (100) @(negedge clk);
    chk("t1_latch_no_req", {31'd0, start_req}, 0);
    @(negedge clk);
    chk("t1_req", {30'd0, start_req, busy}, 32'd3);
    chk("t1_peak", {24'd0, peak_pos}, 10);
    start_ack = 1;
    @(negedge clk);
    chk("t1_send", {30'd0, start_req, busy}, 32'd1);
    foreach (tv[i]) pix(tv[i].idx, tv[i].exp);
    done_pulse();
    chk("t1_done_idle", {31'd0, busy}, 0);

    level = 40;
    wait_req("t2_req");
    chk("t2_peak", {24'd0, peak_pos}, 16);
    @(negedge clk);
    pix(15, CP);
    pix(20, 0);
    pix(14, CH);
    done_pulse();

    reset = 1; level = 12;
    @(negedge clk);
    reset = 0;
    frame("t3_f0", peak_seq[0]);
    level = 4;
    for (int f = 1; f < 22; f++) frame($sformatf("t3_f%0d", f), peak_seq[f]);

    wait_req("t4_req");
    repeat (299) @(negedge clk);
    chk("t4_overrun3", {24'd0, overrun_cnt}, 3);
    chk("t4_send_held", {31'd0, busy}, 1);
    repeat (99) @(negedge clk);
    done_pulse();
    chk("t4_overrun4", {24'd0, overrun_cnt}, 4);
    chk("t4_wait", {31'd0, busy}, 0);
    repeat (100) @(negedge clk);
    chk("t4_latch", {31'd0, start_req}, 0);
    @(negedge clk);
    chk("t4_next_req", {31'd0, start_req}, 1);
    @(negedge clk);
    done_pulse();

    start_ack = 0;
    wait_req("t5_req");
    is_enable = 0;
    @(negedge clk);
    chk("t5_abort", {30'd0, start_req, busy}, 0);
    repeat (3) @(negedge clk);
    chk("t5_idle", {30'd0, start_req, busy}, 0);
    is_enable = 1; start_ack = 1;
    wait_req("t5_req2");
    @(negedge clk);
    is_enable = 0;
    repeat (5) @(negedge clk);
    chk("t5_send_held", {31'd0, busy}, 1);
    done_pulse();
    chk("t5_send_idle", {31'd0, busy}, 0);
    repeat (150) @(negedge clk);
    chk("t5_stay_idle", {30'd0, start_req, busy}, 0);

    is_enable = 1; level = 9;
    wait_req("t6_req");
    chk("t6_peak", {24'd0, peak_pos}, 9);
    @(negedge clk);
    color_low = 24'h123456; color_peak = 24'h654321;
    pix(0, CL);
    pix(8, CP);
    reset = 1;
    @(negedge clk);
    chk("t6_rst_out", {26'd0, start_req, busy, pix_valid, |pix_color, |peak_pos, |overrun_cnt}, 0);
    reset = 0;
    pix(0, 0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
